// File: rtl/alu_mpseq.sv
// Multi-precision sequencer: runs one WORDS*N-bit operation through a single
// combinational N-bit ALU, least-significant word first, optionally chaining carry.
module alu_mpseq #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [N*WORDS-1:0]   req_a,
  input  logic [N*WORDS-1:0]   req_b,
  input  logic [6:0]           req_op,
  input  logic                 req_cin,
  input  logic                 req_chain,
  output logic [N-1:0]         alu_a,
  output logic [N-1:0]         alu_b,
  output logic [6:0]           alu_op,
  output logic                 alu_cin,
  input  logic [N-1:0]         alu_out,
  input  logic                 alu_cout,
  input  logic                 alu_overflow,
  input  logic                 alu_sign,
  input  logic                 alu_zero,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [N*WORDS-1:0]   res_out,
  output logic                 res_cout,
  output logic                 res_overflow,
  output logic                 res_sign,
  output logic                 res_zero
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_nx;
  logic [WORDS-1:0][N-1:0] a_q, b_q, res_q;
  logic [6:0]              op_q;
  logic                    cin_q, chain_q, carry, zacc;
  logic [IW-1:0]           idx;

  assign alu_op  = op_q;
  assign res_out = res_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // ALU inputs come only from latched operands, so the ALU never sees req_* directly.
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    res_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_cin   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = RUN;
      end
      RUN: begin
        alu_a   = a_q[idx];
        alu_b   = b_q[idx];
        alu_cin = (idx == '0 || !chain_q) ? cin_q : carry;
        if (idx == LAST) state_nx = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      op_q         <= '0;
      cin_q        <= 1'b0;
      chain_q      <= 1'b0;
      carry        <= 1'b0;
      zacc         <= 1'b0;
      idx          <= '0;
      res_cout     <= 1'b0;
      res_overflow <= 1'b0;
      res_sign     <= 1'b0;
      res_zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          a_q     <= req_a;
          b_q     <= req_b;
          op_q    <= req_op;
          cin_q   <= req_cin;
          chain_q <= req_chain;
          idx     <= '0;
          carry   <= req_cin;
          zacc    <= 1'b1;
        end
        RUN: begin
          res_q[idx] <= alu_out;
          carry      <= alu_cout;
          zacc       <= zacc & alu_zero;
          // Top word supplies the wide flags; zero is the AND over every word.
          if (idx == LAST) begin
            res_cout     <= alu_cout;
            res_overflow <= alu_overflow;
            res_sign     <= alu_sign;
            res_zero     <= zacc & alu_zero;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
